// File: rtl/int2flt_pkg.sv
// Shared types and constants for the int16 -> IEEE-754 half converter.
// Holds the FSM state encoding and the default operand/result addresses.
package int2flt_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LD_LO,
    LD_HI,
    ABS,
    NORM,
    PACK,
    ST_LO,
    ST_HI,
    DONE
  } state_t;

  localparam int BIAS         = 15;
  localparam int EXP_MAX_INT  = BIAS + 15;
  localparam int FRAC_W       = 10;
  localparam int DEF_IN_ADDR  = 0;
  localparam int DEF_OUT_ADDR = 2;

endpackage

// File: rtl/int2flt_if.sv
// start/done handshake between a requester (master) and the converter (slave).
// start is a request pulse; done is a level that holds until the next accepted start.
interface int2flt_if;
  logic start;
  logic done;

  modport master (output start, input done);
  modport slave  (input start, output done);
endinterface

// File: rtl/dat_mem.sv
// Byte-wide data memory: asynchronous read, synchronous write, single address port.
// Contents are never reset; writes land on the rising edge when we is high.
module dat_mem #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem_core [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem_core[addr] <= wdata;
  end

  assign rdata = mem_core[addr];

endmodule

// File: rtl/int2flt.sv
// int16 -> half-float converter; latency 7+s cycles (s = normalise shifts), start ignored while busy.
// Truncates the fraction by default; define INT2FLT_ROUND_EN for round-to-nearest-even.
module int2flt
  import int2flt_pkg::*;
#(
  parameter int AW       = 8,
  parameter int IN_ADDR  = DEF_IN_ADDR,
  parameter int OUT_ADDR = DEF_OUT_ADDR
) (
  input  logic     clk,
  input  logic     reset,
  int2flt_if.slave ctrl
);

  state_t        state_q, state_d;
  logic [15:0]   x_q, x_d;
  logic          sign_q, sign_d;
  logic [15:0]   mag_q, mag_d;
  logic [4:0]    exp_q, exp_d;
  logic [15:0]   res_q, res_d;
  logic          done_q, done_d;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  logic [16:0]       x_ext;
  logic [16:0]       mag_abs;
  logic              zero_w;
  logic [FRAC_W-1:0] frac_p;
  logic [4:0]        exp_p;
  logic [15:0]       pack_res;
`ifdef INT2FLT_ROUND_EN
  logic              rnd_up;
  logic [FRAC_W:0]   frac_sum;
`endif

  dat_mem #(.AW(AW)) dm1 (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // 17-bit magnitude so that -32768 negates cleanly to 0x8000.
  assign x_ext   = {x_q[15], x_q};
  assign mag_abs = x_q[15] ? (~x_ext + 17'd1) : x_ext;

  // A zero operand skips NORM, so an all-zero magnitude in PACK means zero input.
  assign zero_w = (mag_q == 16'd0);

  always_comb begin
    frac_p = mag_q[14:5];
    exp_p  = exp_q;
`ifdef INT2FLT_ROUND_EN
    rnd_up   = mag_q[4] & (mag_q[5] | (|mag_q[3:0]));
    frac_sum = {1'b0, mag_q[14:5]} + {{FRAC_W{1'b0}}, rnd_up};
    if (frac_sum[FRAC_W]) begin
      frac_p = '0;
      exp_p  = (exp_q == 5'(EXP_MAX_INT)) ? exp_q : exp_q + 5'd1;
    end else begin
      frac_p = frac_sum[FRAC_W-1:0];
    end
`endif
    pack_res = zero_w ? 16'h0000 : {sign_q, exp_p, frac_p};
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    exp_d     = exp_q;
    res_d     = res_q;
    mem_we    = 1'b0;
    mem_addr  = AW'(IN_ADDR);
    mem_wdata = res_q[7:0];

    unique case (state_q)
      IDLE: if (ctrl.start) state_d = LD_LO;
      LD_LO: begin
        mem_addr  = AW'(IN_ADDR);
        x_d[7:0]  = mem_rdata;
        state_d   = LD_HI;
      end
      LD_HI: begin
        mem_addr  = AW'(IN_ADDR + 1);
        x_d[15:8] = mem_rdata;
        state_d   = ABS;
      end
      ABS: begin
        sign_d  = x_q[15];
        mag_d   = mag_abs[15:0];
        exp_d   = 5'(EXP_MAX_INT);
        state_d = (mag_abs == 17'd0) ? PACK : NORM;
      end
      NORM: begin
        if (!mag_q[15]) begin
          mag_d = {mag_q[14:0], 1'b0};
          exp_d = exp_q - 5'd1;
        end else begin
          state_d = PACK;
        end
      end
      PACK: begin
        res_d   = pack_res;
        state_d = ST_LO;
      end
      ST_LO: begin
        mem_we    = 1'b1;
        mem_addr  = AW'(OUT_ADDR);
        mem_wdata = res_q[7:0];
        state_d   = ST_HI;
      end
      ST_HI: begin
        mem_we    = 1'b1;
        mem_addr  = AW'(OUT_ADDR + 1);
        mem_wdata = res_q[15:8];
        state_d   = DONE;
      end
      DONE: if (ctrl.start) state_d = LD_LO;
      default: state_d = IDLE;
    endcase

    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      exp_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign ctrl.done = done_q;

endmodule

// File: tb/tb_int2flt.sv
// Directed bench for int2flt: vector table plus reset, back-to-back and busy-start sequences.
module tb_int2flt;
  import int2flt_pkg::*;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  int2flt_if ctrl_if ();

  int2flt dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (ctrl_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] x;
    logic [15:0] res;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_operand(input logic [15:0] x);
    dut.dm1.mem_core[0] = x[7:0];
    dut.dm1.mem_core[1] = x[15:8];
  endtask

  function automatic logic [15:0] read_result();
    return {dut.dm1.mem_core[3], dut.dm1.mem_core[2]};
  endfunction

  // Called at a negedge; returns cycles from the start-sampling edge to done (-1 on timeout).
  task automatic run_conv(input logic [15:0] x, output int lat, output logic [15:0] res);
    load_operand(x);
    ctrl_if.start = 1'b1;
    @(negedge clk);
    ctrl_if.start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (ctrl_if.done) begin
        lat = c;
        break;
      end
    end
    res = read_result();
  endtask

  vec_t        vecs [10];
  int          lat;
  logic [15:0] res;

  initial begin
    n_chk  = 0;
    n_fail = 0;

    vecs[0] = '{16'h0000, 16'h0000, 6};
    vecs[1] = '{16'h0001, 16'h3C00, 22};
    vecs[2] = '{16'hFFFF, 16'hBC00, 22};
    vecs[3] = '{16'h03E8, 16'h63D0, 13};
    vecs[4] = '{16'hFC18, 16'hE3D0, 13};
`ifdef INT2FLT_ROUND_EN
    vecs[5] = '{16'h7FFF, 16'h7800, 8};
    vecs[7] = '{16'h0803, 16'h6802, 11};
`else
    vecs[5] = '{16'h7FFF, 16'h77FF, 8};
    vecs[7] = '{16'h0803, 16'h6801, 11};
`endif
    vecs[6] = '{16'h8000, 16'hF800, 7};
    vecs[8] = '{16'h0801, 16'h6800, 11};
    vecs[9] = '{16'h0002, 16'h4000, 21};

    ctrl_if.start = 1'b0;
    reset         = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_done", 32'(ctrl_if.done), 32'd0);
    check("reset_state", 32'(dut.state_q), 32'(IDLE));
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_conv(vecs[i].x, lat, res);
      check($sformatf("res_%h", vecs[i].x), 32'(res), 32'(vecs[i].res));
      check($sformatf("lat_%h", vecs[i].x), 32'(lat), 32'(vecs[i].lat));
    end

    // done holds with no new start
    repeat (4) @(negedge clk);
    check("done_hold", 32'(ctrl_if.done), 32'd1);
    check("hold_res", 32'(read_result()), 32'h4000);

    // back-to-back: start in DONE drops done on the next edge
    load_operand(16'h03E8);
    ctrl_if.start = 1'b1;
    @(negedge clk);
    ctrl_if.start = 1'b0;
    check("b2b_done_drop", 32'(ctrl_if.done), 32'd0);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (ctrl_if.done) begin
        lat = c;
        break;
      end
    end
    check("b2b_lat", 32'(lat), 32'd13);
    check("b2b_res", 32'(read_result()), 32'h63D0);

    // start pulse while busy is ignored
    load_operand(16'h0001);
    ctrl_if.start = 1'b1;
    @(negedge clk);
    ctrl_if.start = 1'b0;
    repeat (5) @(negedge clk);
    ctrl_if.start = 1'b1;
    @(negedge clk);
    ctrl_if.start = 1'b0;
    lat = -1;
    for (int c = 7; c <= 40; c++) begin
      @(negedge clk);
      if (ctrl_if.done) begin
        lat = c;
        break;
      end
    end
    check("busy_lat", 32'(lat), 32'd22);
    check("busy_res", 32'(read_result()), 32'h3C00);
    repeat (3) @(negedge clk);
    check("busy_stay_done", 32'(ctrl_if.done), 32'd1);

    // reset during NORM aborts the conversion
    load_operand(16'h0001);
    ctrl_if.start = 1'b1;
    @(negedge clk);
    ctrl_if.start = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_state", 32'(dut.state_q), 32'(NORM));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_norm_done", 32'(ctrl_if.done), 32'd0);
    check("rst_norm_state", 32'(dut.state_q), 32'(IDLE));
    repeat (3) @(negedge clk);
    check("rst_idle_stay", 32'(dut.state_q), 32'(IDLE));
    run_conv(16'h0002, lat, res);
    check("post_rst_res", 32'(res), 32'h4000);
    check("post_rst_lat", 32'(lat), 32'd21);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/int2flt.md
Name: int2flt

Overview:
- Sequential converter from a 16-bit two's-complement integer to IEEE-754 half precision (1 sign, 5 exponent, 10 fraction bits, bias 15).
- Reverse-direction companion to the team's float-to-integer block; uses the same start/done handshake and the same data-memory convention.
- The operand is read from its own data memory instance `dm1` (bytes 1:0, hi:lo). The result is written back to bytes 3:2 (hi:lo).
- Benches inject the operand and read the result through hierarchical access to `dm1.mem_core`.

Parameters:
- AW, 8, data-memory address width (depth 2**AW bytes).
- IN_ADDR, 0, address of the operand low byte; the high byte is at IN_ADDR+1.
- OUT_ADDR, 2, address of the result low byte; the high byte is at OUT_ADDR+1.

Ports:
- clk    input   1  single clock; all state changes on the rising edge.
- reset  input   1  synchronous, active-high reset.
- start  input   1  request; sampled only in IDLE.
- done   output  1  high while the result in memory is valid and the block is idle.

Behaviour:
- Reset: sampled high at a clock edge.
  - State returns to IDLE; done=0; internal registers are cleared.
  - Memory contents are not cleared.
  - Reset overrides an in-progress conversion at any state; a partial result may remain in memory.
- Memory `dm1`: byte-wide, asynchronous read, synchronous write, one address port.
- FSM states and transitions:
  - IDLE: if start=1, go to LD_LO; else stay.
  - LD_LO: latch mem[IN_ADDR] into the low byte; go to LD_HI.
  - LD_HI: latch mem[IN_ADDR+1] into the high byte; go to ABS.
  - ABS:
    - sign = x[15]; mag (17-bit) = sign ? -x : x, so -32768 gives mag=0x8000.
    - exp = 30.
    - If mag==0, go to PACK with a zero flag; else go to NORM.
  - NORM:
    - If mag[15]=0: mag <<= 1, exp -= 1, stay in NORM.
    - Else go to PACK.
    - One shift per cycle, at most 15 cycles.
  - PACK:
    - result = {sign, exp[4:0], mag[14:5]}; mag[4:0] are discarded (truncation).
    - With the zero flag, result = 16'h0000 (no negative zero).
  - ST_LO: write result[7:0] to OUT_ADDR; go to ST_HI.
  - ST_HI: write result[15:8] to OUT_ADDR+1; go to DONE.
  - DONE:
    - done=1.
    - If start=1, clear done and go to LD_LO; else stay.
    - done is registered and deasserts on the same edge the new conversion begins.
- Latency: N = 7 + s cycles from the edge that samples start to the first cycle with done=1, where s = number of NORM shifts (0..15). Worst case is 22 cycles, for input 1.
- start held high through completion immediately restarts a conversion; benches pulse start for one cycle.
- Exponent range is 15..30 for nonzero inputs, so the result is never infinity or NaN. No denormals are produced.

Optional Feature:
- Macro: `INT2FLT_ROUND_EN`.
- Defined:
  - PACK applies round-to-nearest-even using lsb=mag[5], guard=mag[4], sticky=|mag[3:0].
  - Increment when guard & (sticky | lsb).
  - Fraction overflow sets the fraction to 0 and exp+1; the maximum exponent remains 30.
  - Latency is unchanged.
- Undefined: truncation as above.

Decomposition:
- Package `int2flt_pkg`:
  - state enum (IDLE, LD_LO, LD_HI, ABS, NORM, PACK, ST_LO, ST_HI, DONE);
  - localparams BIAS=15, EXP_MAX_INT=30, FRAC_W=10;
  - default IN_ADDR and OUT_ADDR.
- Sub-module: `dat_mem`, instantiated as `dm1` with array `mem_core`. This is the same memory block used by the float-to-int design, shared unchanged.
- FSM, datapath and rounding stay in `int2flt`.

Test Plan:
- 16'h0000 -> mem[3:2]=16'h0000; 0x0001 -> 16'h3C00 after 22 cycles; 16'hFFFF (-1) -> 16'hBC00.
- 1000 (16'h03E8) -> 16'h63D0; -1000 -> 16'hE3D0; done stays high until the next start.
- 32767 -> 16'h77FF (truncation), or 16'h7800 with `INT2FLT_ROUND_EN`; -32768 (16'h8000) -> 16'hF800 in both builds.
- 2051 (16'h0803) -> 16'h6801 truncated, or 16'h6802 with rounding (tie to even). 2049 -> 16'h6800 in both builds.
- Reset asserted for one cycle during NORM (input 1) -> done=0 on the next cycle and state IDLE. A following start with input 2 -> 16'h4000 with correct latency.
- Back-to-back: start pulsed in DONE with a new operand -> done drops on the next edge, then rises with the new result. A start pulse while busy is ignored.
